instr_mem_responder: RTL

//  Instruction-memory side of the fetch interface. Answers the fetch unit's

---
 rtl/instr_mem_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fetch-side instruction memory with a registered one-cycle read and a valid/ready program load port.
module instr_mem_responder #(
    parameter int I_WIDTH       = 16,
    parameter int IM_ADDR_WIDTH = 16,
    parameter int DEPTH         = 256
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic [IM_ADDR_WIDTH-1:0] iInstructionAddress,
    input  logic                     iInstructionReadEnable,
    output logic [I_WIDTH-1:0]       oInstruction,
    output logic                     oInstructionValid,
    output logic                     oAddrError,
    input  logic                     iLoadStart,
    input  logic [IM_ADDR_WIDTH-1:0] iLoadBase,
    input  logic [IM_ADDR_WIDTH-1:0] iLoadCount,
    input  logic [I_WIDTH-1:0]       iLoadData,
    input  logic                     iLoadValid,
    output logic                     oLoadReady,
    output logic                     oLoadDone,
    output logic                     oBusy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**IM_ADDR_WIDTH still compares and divides correctly.
    localparam logic [IM_ADDR_WIDTH:0] DEPTH_W = (IM_ADDR_WIDTH+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                   state_q;
    logic [AW-1:0]            wptr_q, wptr_d, base_w, raddr;
    logic [IM_ADDR_WIDTH-1:0] remaining_q;
    logic [I_WIDTH-1:0]       mem_q [DEPTH];
    logic [I_WIDTH-1:0]       instr_q;
    logic                     valid_q, err_q, hs, rd_ok, serve;
    assign hs     = iReset && state_q == LOAD && iLoadValid;
    assign rd_ok  = {1'b0, iInstructionAddress} < DEPTH_W;
    assign serve  = iInstructionReadEnable && state_q != LOAD;
    assign base_w = AW'({1'b0, iLoadBase} % DEPTH_W);
    assign raddr  = iInstructionAddress[AW-1:0];
    assign wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (iLoadStart) begin
                    wptr_q      <= base_w;
                    remaining_q <= iLoadCount;
                    state_q     <= (iLoadCount != '0) ? LOAD : DONE;
                end
                LOAD: if (iLoadValid) begin
                    wptr_q      <= wptr_d;
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == IM_ADDR_WIDTH'(1)) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    always_ff @(posedge iClk) begin
        if (hs) mem_q[wptr_q] <= iLoadData;
    end
    // Reads are blanked during LOAD so a fetch never sees a half-written image.
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= (serve && rd_ok) ? mem_q[raddr] : '0;
            valid_q <= serve;
            err_q   <= err_q | (serve && !rd_ok);
        end
    end
    assign oInstruction      = instr_q;
    assign oInstructionValid = valid_q;
    assign oAddrError        = err_q;
    assign oLoadReady        = state_q == LOAD;
    assign oLoadDone         = state_q == DONE;
    assign oBusy             = state_q != IDLE;
endmodule
